dma_rd_desc_splitter: RTL and testbench

Upstream feeder for the AXI DMA read engine. Accepts one large read request (byte address + byte length) and issues a sequence of read descriptors into the engine's `s_axis_read_desc_*` port. Each descriptor is capped at `MAX_DESC_LEN` bytes and never crosses a `BOUNDARY`-byte address boundary. The block counts outstanding descriptors against the engine's completion status and pulses `done` once every issued descriptor has completed.

---
 rtl/dma_rd_desc_splitter_if.sv | 33 +++
 rtl/dma_rd_desc_splitter.sv | 105 ++++++++++
 tb/tb_dma_rd_desc_splitter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_rd_desc_splitter_if.sv
// rtl/dma_rd_desc_splitter_if.sv - request, read-descriptor and completion-status signals of the splitter
interface dma_rd_desc_splitter_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 9,
  parameter int REQ_LEN_WIDTH  = 20
);
  logic [AXI_ADDR_WIDTH-1:0] s_req_addr;
  logic [REQ_LEN_WIDTH-1:0]  s_req_len;
  logic                      s_req_valid;
  logic                      s_req_ready;
  logic [AXI_ADDR_WIDTH-1:0] m_axis_read_desc_addr;
  logic [LEN_WIDTH-1:0]      m_axis_read_desc_len;
  logic                      m_axis_read_desc_valid;
  logic                      m_axis_read_desc_ready;
  logic                      s_axis_read_desc_status_valid;

  // master: the splitter itself; slave: the requester plus the DMA read engine
  modport master (
    input  s_req_addr, s_req_len, s_req_valid,
    output s_req_ready,
    output m_axis_read_desc_addr, m_axis_read_desc_len, m_axis_read_desc_valid,
    input  m_axis_read_desc_ready,
    input  s_axis_read_desc_status_valid
  );

  modport slave (
    output s_req_addr, s_req_len, s_req_valid,
    input  s_req_ready,
    input  m_axis_read_desc_addr, m_axis_read_desc_len, m_axis_read_desc_valid,
    output m_axis_read_desc_ready,
    output s_axis_read_desc_status_valid
  );
endinterface

// File: rtl/dma_rd_desc_splitter.sv
// rtl/dma_rd_desc_splitter.sv - splits one read request into capped, boundary-safe DMA read descriptors
module dma_rd_desc_splitter #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH       = 9,
  parameter int REQ_LEN_WIDTH   = 20,
  parameter int MAX_DESC_LEN    = 256,
  parameter int BOUNDARY        = 4096,
  parameter int MAX_OUTSTANDING = 4,
  localparam int OUT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  dma_rd_desc_splitter_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] outstanding
);
  localparam int CW = REQ_LEN_WIDTH + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BOUND_MASK = AXI_ADDR_WIDTH'(BOUNDARY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state_r, state_n;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [REQ_LEN_WIDTH-1:0]  rem_r;
  logic                      init_r;
  logic [CW-1:0]             rem_w, room_w, chunk_w;
  logic                      req_ready, desc_valid;
  logic                      req_fire, desc_fire, status_in, last_chunk;

  // Chunk = min(remaining, max descriptor, bytes left before the next boundary)
  always_comb begin
    rem_w   = {1'b0, rem_r};
    room_w  = CW'(BOUNDARY) - CW'(addr_r & BOUND_MASK);
    chunk_w = CW'(MAX_DESC_LEN);
    if (room_w < chunk_w) chunk_w = room_w;
    if (rem_w < chunk_w)  chunk_w = rem_w;
  end

  assign last_chunk = (chunk_w == rem_w);
  assign status_in  = bus.s_axis_read_desc_status_valid;
  assign req_fire   = req_ready && bus.s_req_valid;
  assign desc_fire  = desc_valid && bus.m_axis_read_desc_ready;

  assign bus.s_req_ready            = req_ready;
  assign bus.m_axis_read_desc_valid = desc_valid;
  assign bus.m_axis_read_desc_addr  = addr_r;
  assign bus.m_axis_read_desc_len   = chunk_w[LEN_WIDTH-1:0];
  assign busy                       = (state_r != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_n;
  end

  always_comb begin
    state_n    = state_r;
    req_ready  = 1'b0;
    desc_valid = 1'b0;
    done       = 1'b0;
    case (state_r)
      IDLE: begin
        // init_r keeps ready low until the first edge after reset release
        req_ready = init_r;
        if (init_r && bus.s_req_valid)
          state_n = (bus.s_req_len != '0) ? ISSUE : DRAIN;
      end
      ISSUE: begin
        desc_valid = (outstanding < OUT_WIDTH'(MAX_OUTSTANDING));
        if (desc_valid && bus.m_axis_read_desc_ready && last_chunk)
          state_n = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r      <= '0;
      rem_r       <= '0;
      init_r      <= 1'b0;
      outstanding <= '0;
    end else begin
      init_r <= 1'b1;
      if (req_fire) begin
        addr_r <= bus.s_req_addr;
        rem_r  <= bus.s_req_len;
      end else if (desc_fire) begin
        addr_r <= addr_r + AXI_ADDR_WIDTH'(chunk_w);
        rem_r  <= rem_r - chunk_w[REQ_LEN_WIDTH-1:0];
      end
      // Stray completions with nothing in flight are dropped
      if (desc_fire && !status_in)
        outstanding <= outstanding + OUT_WIDTH'(1);
      else if (!desc_fire && status_in && outstanding != '0)
        outstanding <= outstanding - OUT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_dma_rd_desc_splitter.sv
// tb/tb_dma_rd_desc_splitter.sv - scoreboard bench for dma_rd_desc_splitter
module tb_dma_rd_desc_splitter;
  localparam int AW = 32;
  localparam int LW = 9;
  localparam int RW = 20;
  localparam int OW = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } desc_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy, done;
  logic [OW-1:0] outstanding;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  desc_t         exp_q[$];
  desc_t         act_q[$];
  int            act_cyc[$];

  dma_rd_desc_splitter_if #(.AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .REQ_LEN_WIDTH(RW)) bus();

  dma_rd_desc_splitter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Descriptor observed mid-cycle; it is accepted at the following rising edge
  always @(negedge clk) begin
    if (!rst && bus.m_axis_read_desc_valid && bus.m_axis_read_desc_ready) begin
      act_q.push_back({bus.m_axis_read_desc_addr, bus.m_axis_read_desc_len});
      act_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input logic [RW-1:0] l);
    int n = 0;
    while (bus.s_req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout: s_req_ready=%b after %0d cycles, required 1", bus.s_req_ready, n);
    end
    bus.s_req_addr  = a;
    bus.s_req_len   = l;
    bus.s_req_valid = 1'b1;
    tick();
    bus.s_req_valid = 1'b0;
  endtask

  task automatic pulse_status();
    bus.s_axis_read_desc_status_valid = 1'b1;
    tick();
    bus.s_axis_read_desc_status_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.s_req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b required 0", bus.s_req_ready); end
    checks++; if (bus.m_axis_read_desc_valid !== 1'b0) begin failures++; $display("FAIL reset_desc_valid: got %b required 0", bus.m_axis_read_desc_valid); end
    checks++; if (bus.m_axis_read_desc_addr !== '0) begin failures++; $display("FAIL reset_desc_addr: got %h required 0", bus.m_axis_read_desc_addr); end
    checks++; if (bus.m_axis_read_desc_len !== '0) begin failures++; $display("FAIL reset_desc_len: got %0d required 0", bus.m_axis_read_desc_len); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got busy=%b done=%b required 0 0", busy, done); end
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL reset_outstanding: got %0d required 0", outstanding); end
    rst = 1'b0;
    tick();
    checks++; if (bus.s_req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b required 1", bus.s_req_ready); end
  endtask

  task automatic test_single();
    desc_t e, a;
    bus.m_axis_read_desc_ready = 1'b1;
    exp_q.push_back({32'h8, 9'd80});
    send_req(32'h8, 20'd80);
    checks++; if (bus.m_axis_read_desc_valid !== 1'b1) begin failures++; $display("FAIL single_valid_latency: got %b required 1", bus.m_axis_read_desc_valid); end
    tick();
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_outstanding: got %0d required 1", outstanding); end
    pulse_status();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done: got %b required 1", done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_after_done: got done=%b busy=%b required 0 0", done, busy); end
    checks++; if (bus.s_req_ready !== 1'b1) begin failures++; $display("FAIL single_ready_back: got %b required 1", bus.s_req_ready); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL single_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); void'(act_cyc.pop_front());
        if (a !== e) begin failures++; $display("FAIL single_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL single_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_length_split();
    desc_t e, a;
    int c, prev;
    prev = -1;
    bus.m_axis_read_desc_ready = 1'b1;
    exp_q.push_back({32'h000, 9'd256});
    exp_q.push_back({32'h100, 9'd256});
    exp_q.push_back({32'h200, 9'd88});
    send_req(32'h0, 20'd600);
    repeat (3) tick();
    checks++; if (outstanding !== 3'd3 || bus.m_axis_read_desc_valid !== 1'b0) begin failures++; $display("FAIL split_issued: got outstanding=%0d valid=%b required 3 0", outstanding, bus.m_axis_read_desc_valid); end
    for (int i = 0; i < 3; i++) begin
      pulse_status();
      checks++;
      if (done !== (i == 2)) begin failures++; $display("FAIL split_done_pulse%0d: got %b required %b", i, done, (i == 2)); end
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL split_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); c = act_cyc.pop_front();
        if (a !== e) begin failures++; $display("FAIL split_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
        else if (prev >= 0 && c != prev + 1) begin failures++; $display("FAIL split_back_to_back: got cycle %0d required %0d", c, prev + 1); end
        prev = c;
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL split_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_boundary();
    desc_t e, a;
    bus.m_axis_read_desc_ready = 1'b1;
    exp_q.push_back({32'hFF0, 9'd16});
    exp_q.push_back({32'h1000, 9'd48});
    send_req(32'hFF0, 20'd64);
    repeat (2) tick();
    pulse_status();
    pulse_status();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL boundary_done: got %b required 1", done); end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL boundary_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); void'(act_cyc.pop_front());
        if (a !== e) begin failures++; $display("FAIL boundary_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL boundary_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_outstanding_limit();
    desc_t e, a;
    bus.m_axis_read_desc_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back({AW'(i * 256), 9'd256});
    send_req(32'h0, 20'd1280);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.m_axis_read_desc_valid !== 1'b0 || outstanding !== 3'd4) begin failures++; $display("FAIL limit_hold%0d: got valid=%b outstanding=%0d required 0 4", i, bus.m_axis_read_desc_valid, outstanding); end
      tick();
    end
    pulse_status();
    checks++; if (bus.m_axis_read_desc_valid !== 1'b1 || bus.m_axis_read_desc_addr !== 32'h400 || bus.m_axis_read_desc_len !== 9'd256) begin
      failures++; $display("FAIL limit_fifth: got valid=%b %h/%0d required 1 400/256", bus.m_axis_read_desc_valid, bus.m_axis_read_desc_addr, bus.m_axis_read_desc_len);
    end
    pulse_status();
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL limit_concurrent: got outstanding=%0d required 3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      pulse_status();
      checks++;
      if (done !== (i == 2)) begin failures++; $display("FAIL limit_done%0d: got %b required %b", i, done, (i == 2)); end
    end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL limit_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); void'(act_cyc.pop_front());
        if (a !== e) begin failures++; $display("FAIL limit_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL limit_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_zero_length();
    bus.m_axis_read_desc_ready = 1'b1;
    send_req(32'h40, 20'd0);
    checks++; if (done !== 1'b1 || bus.m_axis_read_desc_valid !== 1'b0) begin failures++; $display("FAIL zero_done: got done=%b valid=%b required 1 0", done, bus.m_axis_read_desc_valid); end
    tick();
    checks++; if (done !== 1'b0 || bus.s_req_ready !== 1'b1) begin failures++; $display("FAIL zero_after: got done=%b ready=%b required 0 1", done, bus.s_req_ready); end
    pulse_status();
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL zero_stray_status: got outstanding=%0d required 0", outstanding); end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL zero_no_desc: got %0d descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_backpressure();
    desc_t e, a;
    bus.m_axis_read_desc_ready = 1'b0;
    exp_q.push_back({32'h100, 9'd128});
    send_req(32'h100, 20'd128);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.m_axis_read_desc_valid !== 1'b1 || bus.m_axis_read_desc_addr !== 32'h100 || bus.m_axis_read_desc_len !== 9'd128) begin
        failures++; $display("FAIL backpressure_hold%0d: got valid=%b %h/%0d required 1 100/128", i, bus.m_axis_read_desc_valid, bus.m_axis_read_desc_addr, bus.m_axis_read_desc_len);
      end
      tick();
    end
    bus.m_axis_read_desc_ready = 1'b1;
    tick();
    pulse_status();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL backpressure_done: got %b required 1", done); end
    tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL backpressure_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); void'(act_cyc.pop_front());
        if (a !== e) begin failures++; $display("FAIL backpressure_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL backpressure_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  task automatic test_reset_mid();
    desc_t e, a;
    bus.m_axis_read_desc_ready = 1'b1;
    exp_q.push_back({32'h000, 9'd256});
    exp_q.push_back({32'h100, 9'd256});
    send_req(32'h0, 20'd600);
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.m_axis_read_desc_valid !== 1'b0 || bus.s_req_ready !== 1'b0) begin failures++; $display("FAIL midreset_handshakes: got valid=%b ready=%b required 0 0", bus.m_axis_read_desc_valid, bus.s_req_ready); end
    checks++; if (bus.m_axis_read_desc_addr !== '0 || bus.m_axis_read_desc_len !== '0) begin failures++; $display("FAIL midreset_desc: got %h/%0d required 0/0", bus.m_axis_read_desc_addr, bus.m_axis_read_desc_len); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || outstanding !== '0) begin failures++; $display("FAIL midreset_state: got busy=%b done=%b outstanding=%0d required 0 0 0", busy, done, outstanding); end
    tick();
    rst = 1'b0;
    pulse_status();
    checks++; if (outstanding !== '0) begin failures++; $display("FAIL midreset_stray_status: got outstanding=%0d required 0", outstanding); end
    exp_q.push_back({32'h20, 9'd40});
    send_req(32'h20, 20'd40);
    tick();
    pulse_status();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL midreset_rerun_done: got %b required 1", done); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_rerun_busy: got %b required 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin failures++; $display("FAIL midreset_desc: got none required %h/%0d", e.addr, e.len); end
      else begin
        a = act_q.pop_front(); void'(act_cyc.pop_front());
        if (a !== e) begin failures++; $display("FAIL midreset_desc: got %h/%0d required %h/%0d", a.addr, a.len, e.addr, e.len); end
      end
    end
    checks++; if (act_q.size() != 0) begin failures++; $display("FAIL midreset_extra: got %0d extra descriptors required 0", act_q.size()); act_q.delete(); act_cyc.delete(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.s_req_addr = '0;
    bus.s_req_len = '0;
    bus.s_req_valid = 1'b0;
    bus.m_axis_read_desc_ready = 1'b0;
    bus.s_axis_read_desc_status_valid = 1'b0;
    test_reset();
    test_single();
    test_length_split();
    test_boundary();
    test_outstanding_limit();
    test_zero_length();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
